exp_range_reduction: RTL and testbench

Argument range-reduction stage placed directly upstream of the hyperbolic exp CORDIC in the diode-shunt datapath. It accepts a signed diode exponent argument x and splits it as x = k·ln2 + r, with |r| ≤ ln2/2. It emits r in the CORDIC's 2.14 input format and the integer k for the downstream 2^k rescale. The reduction is iterative, one ln2 add or subtract per clock, with valid/ready handshakes on both sides.

---
 rtl/exp_range_reduction_if.sv | 42 ++++
 rtl/exp_range_reduction.sv | 125 ++++++++++++
 tb/tb_exp_range_reduction.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/exp_range_reduction_if.sv
// ---------------------------------------------------------------------------
// exp_range_reduction_if
// Handshake bundle for the exp range-reduction stage.
//   Input stream : x (signed Q5.11), in_valid, in_ready
//   Output stream: z (signed Q2.14), k (signed int), out_valid, out_ready
// Modports:
//   master - the environment side: drives x/in_valid/out_ready, sees results
//   slave  - the reduction block itself
// ---------------------------------------------------------------------------
interface exp_range_reduction_if #(
    parameter int IN_W  = 16,
    parameter int NUM_W = 16,
    parameter int K_W   = 6
);
    logic [IN_W-1:0]  x;
    logic             in_valid;
    logic             in_ready;
    logic [NUM_W-1:0] z;
    logic [K_W-1:0]   k;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output x,
        output in_valid,
        input  in_ready,
        input  z,
        input  k,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  x,
        input  in_valid,
        output in_ready,
        output z,
        output k,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/exp_range_reduction.sv
// ---------------------------------------------------------------------------
// exp_range_reduction
// Splits a signed diode exponent argument x into x = k*ln2 + r, |r| <= ln2/2,
// one ln2 add/subtract per clock. r goes to the hyperbolic exp CORDIC as z0
// (signed Q2.14); k goes to the downstream 2^k rescale.
// Ports:
//   clk   - clock, rising edge
//   rstn  - asynchronous active-low reset
//   bus   - slave view of exp_range_reduction_if
//           x (Q5.11) / in_valid / in_ready   : argument input stream
//           z (Q2.14) / k / out_valid / out_ready : result output stream
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | in_ready high, waiting for an argument
// REDUCE | stepping acc toward [-ln2/2, ln2/2], counting steps in kcnt
// DONE   | result presented, out_valid held until consumed
// ---------------------------------------------------------------------------
module exp_range_reduction (
    input  logic                  clk,
    input  logic                  rstn,
    exp_range_reduction_if.slave  bus
);
    localparam int IN_W  = 16;
    localparam int NUM_W = 16;
    localparam int K_W   = 6;
    localparam int ACC_W = 20;

    localparam logic signed [ACC_W-1:0] LN2      = 20'sd11357;
    localparam logic signed [ACC_W-1:0] HALF_LN2 = 20'sd5678;
    localparam logic signed [ACC_W-1:0] NEG_HALF = -20'sd5678;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic signed [ACC_W-1:0] acc_q,       acc_d;
    logic signed [K_W-1:0]   kcnt_q,      kcnt_d;
    logic [NUM_W-1:0]        z_q,         z_d;
    logic [K_W-1:0]          k_q,         k_d;
    logic                    in_ready_q,  in_ready_d;
    logic                    out_valid_q, out_valid_d;

    // Q5.11 -> Q5.14: sign-extend to ACC_W and append three fraction bits.
    logic signed [ACC_W-1:0] x_ext;
    assign x_ext = {{(ACC_W-IN_W-3){bus.x[IN_W-1]}}, bus.x, 3'b000};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            kcnt_q      <= '0;
            z_q         <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            kcnt_q      <= kcnt_d;
            z_q         <= z_d;
            k_q         <= k_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        kcnt_d      = kcnt_q;
        z_d         = z_q;
        k_d         = k_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    acc_d      = x_ext;
                    kcnt_d     = '0;
                    in_ready_d = 1'b0;
                    state_d    = REDUCE;
                end
            end
            REDUCE: begin
                if (acc_q > HALF_LN2) begin
                    acc_d  = acc_q - LN2;
                    kcnt_d = kcnt_q + 6'sd1;
                end else if (acc_q < NEG_HALF) begin
                    acc_d  = acc_q + LN2;
                    kcnt_d = kcnt_q - 6'sd1;
                end else begin
                    // |acc| <= 5678 here, so the low 16 bits are the exact Q2.14 value.
                    z_d         = acc_q[NUM_W-1:0];
                    k_d         = kcnt_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // in_ready returns one edge after the output handshake, never
                // in the same cycle as out_valid.
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.z         = z_q;
    assign bus.k         = k_q;
endmodule

// File: tb/tb_exp_range_reduction.sv
module tb_exp_range_reduction;
    logic clk;
    logic rstn;
    int   n_tests;
    int   n_failed;

    exp_range_reduction_if #(.IN_W(16), .NUM_W(16), .K_W(6)) ifc ();

    exp_range_reduction dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present x, wait for the result; lat counts edges after the accept edge.
    task automatic run_op(input logic signed [15:0] xv, input bit consume,
                          output logic signed [15:0] zr, output logic signed [5:0] kr,
                          output int lat, output bit tmo);
        @(negedge clk);
        ifc.x        = xv;
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        lat = 0;
        while (!ifc.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tmo = !ifc.out_valid;
        zr  = ifc.z;
        kr  = ifc.k;
        if (consume) begin
            @(negedge clk);
            ifc.out_ready = 1'b1;
            @(posedge clk);
            #1;
            ifc.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        ifc.x = '0;
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_tests++; if (ifc.in_ready !== 1'b1) begin n_failed++; $display("FAIL reset_in_ready got %b exp 1", ifc.in_ready); end
        n_tests++; if (ifc.out_valid !== 1'b0) begin n_failed++; $display("FAIL reset_out_valid got %b exp 0", ifc.out_valid); end
        n_tests++; if (ifc.z !== 16'd0) begin n_failed++; $display("FAIL reset_z got %0d exp 0", $signed(ifc.z)); end
        n_tests++; if (ifc.k !== 6'd0) begin n_failed++; $display("FAIL reset_k got %0d exp 0", $signed(ifc.k)); end
    endtask

    task automatic test_vectors();
        logic signed [15:0] xs [7];
        logic signed [15:0] ze [7];
        logic signed [5:0]  ke [7];
        logic signed [15:0] zr;
        logic signed [5:0]  kr;
        int lat;
        bit tmo;
        xs = '{16'sd0, 16'sd2048, -16'sd2048, 16'sd32767, -16'sd32768, 16'sd3549, -16'sd3549};
        ze = '{16'sd0, 16'sd5027, -16'sd5027, 16'sd925,   -16'sd933,   16'sd5678, -16'sd5678};
        ke = '{6'sd0,  6'sd1,     -6'sd1,     6'sd23,     -6'sd23,     6'sd2,     -6'sd2};
        for (int i = 0; i < 7; i++) begin
            run_op(xs[i], 1'b1, zr, kr, lat, tmo);
            n_tests++;
            if (tmo) begin
                n_failed++;
                $display("FAIL vec%0d_timeout x=%0d no out_valid within 40 cycles", i, xs[i]);
            end else begin
                n_tests++; if (zr !== ze[i]) begin n_failed++; $display("FAIL vec%0d_z x=%0d got %0d exp %0d", i, xs[i], zr, ze[i]); end
                n_tests++; if (kr !== ke[i]) begin n_failed++; $display("FAIL vec%0d_k x=%0d got %0d exp %0d", i, xs[i], kr, ke[i]); end
                n_tests++;
                if (lat !== ((ke[i] < 0) ? -int'(ke[i]) : int'(ke[i])) + 1) begin
                    n_failed++;
                    $display("FAIL vec%0d_latency x=%0d got %0d exp %0d", i, xs[i], lat,
                             ((ke[i] < 0) ? -int'(ke[i]) : int'(ke[i])) + 1);
                end
            end
            n_tests++; if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
                n_failed++; $display("FAIL vec%0d_post_handshake in_ready=%b out_valid=%b exp 1/0", i, ifc.in_ready, ifc.out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [15:0] zr;
        logic signed [5:0]  kr;
        int lat;
        bit tmo;
        run_op(-16'sd2048, 1'b0, zr, kr, lat, tmo);
        n_tests++; if (tmo || zr !== -16'sd5027 || kr !== -6'sd1) begin
            n_failed++; $display("FAIL bp_first_result tmo=%b z=%0d k=%0d exp z=-5027 k=-1", tmo, zr, kr);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            ifc.x        = 16'sd4096;
            ifc.in_valid = c[0];
            n_tests++;
            if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0 ||
                $signed(ifc.z) !== -16'sd5027 || $signed(ifc.k) !== -6'sd1) begin
                n_failed++;
                $display("FAIL bp_hold_c%0d out_valid=%b in_ready=%b z=%0d k=%0d exp 1/0/-5027/-1",
                         c, ifc.out_valid, ifc.in_ready, $signed(ifc.z), $signed(ifc.k));
            end
        end
        @(negedge clk);
        ifc.x         = 16'sd2048;
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        n_tests++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
            n_failed++; $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", ifc.out_valid, ifc.in_ready);
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        n_tests++; if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0) begin
            n_failed++; $display("FAIL bp_next_accept in_ready=%b out_valid=%b exp 0/0", ifc.in_ready, ifc.out_valid);
        end
        lat = 0;
        while (!ifc.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_tests++; if (ifc.out_valid !== 1'b1 || lat !== 2 || $signed(ifc.z) !== 16'sd5027 || $signed(ifc.k) !== 6'sd1) begin
            n_failed++; $display("FAIL bp_next_result ov=%b lat=%0d z=%0d k=%0d exp 1/2/5027/1",
                                 ifc.out_valid, lat, $signed(ifc.z), $signed(ifc.k));
        end
        @(negedge clk);
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_reduce();
        logic signed [15:0] zr;
        logic signed [5:0]  kr;
        int lat;
        bit tmo;
        int seen;
        @(negedge clk);
        ifc.x        = 16'sd32767;
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        n_tests++; if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
            n_failed++; $display("FAIL mid_reset_immediate in_ready=%b out_valid=%b exp 1/0", ifc.in_ready, ifc.out_valid);
        end
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ifc.out_valid) seen++;
        end
        n_tests++; if (seen !== 0) begin
            n_failed++; $display("FAIL mid_reset_no_result out_valid high for %0d cycles exp 0", seen);
        end
        run_op(16'sd2048, 1'b1, zr, kr, lat, tmo);
        n_tests++; if (tmo || zr !== 16'sd5027 || kr !== 6'sd1 || lat !== 2) begin
            n_failed++; $display("FAIL mid_reset_recover tmo=%b z=%0d k=%0d lat=%0d exp 5027/1/2", tmo, zr, kr, lat);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_reduce();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
